qpsk_demap: RTL and testbench

//  Receive-side counterpart of the QPSK mapper: hard-decision demapper converting equalised,

---
 rtl/qpsk_demap_if.sv | 14 +
 rtl/qpsk_demap.sv | 160 ++++++++++++++++
 tb/tb_qpsk_demap.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qpsk_demap_if.sv
// Stream bus bundle for the QPSK demapper: data, write qualifier, strobe,
// cycle framing and the returning acknowledge. W sets the data width.
interface qpsk_demap_if #(
    parameter int W = 2
);
    logic [W-1:0] dat;
    logic         we;
    logic         stb;
    logic         cyc;
    logic         ack;

    modport master (output dat, output we, output stb, output cyc, input ack);
    modport slave  (input dat, input we, input stb, input cyc, output ack);
endinterface

// File: rtl/qpsk_demap.sv
// Hard-decision QPSK demapper: sign of Re/Im of each accepted sample becomes
// a 2-bit symbol, buffered in a 2-entry skid FIFO and framed in groups of NSYM
// output transfers. A frame ended early by the upstream pulses SHORT_O.
// NSYM must be at least 2.
module qpsk_demap #(
    parameter int NSYM = 192,
    parameter int DW   = 16
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    qpsk_demap_if.slave   in_bus,
    qpsk_demap_if.master  out_bus,
    output logic          SHORT_O
);
    localparam int CW = $clog2(NSYM + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        CLOSE  = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic [CW-1:0]  count_r;
    logic [CW-1:0]  count_s;

    logic [1:0]     mem_r [2];
    logic           rd_ptr_r;
    logic           wr_ptr_r;
    logic [1:0]     fifo_cnt_r;

    logic           ack_s;
    logic           push_s;
    logic           pop_s;
    logic           cyc_s;
    logic           short_s;

    // Sign decision: negative component -> 1, zero or positive -> 0.
    function automatic logic [1:0] sign_decide(input logic [2*DW-1:0] d);
        return {d[2*DW-1], d[DW-1]};
    endfunction

    // Input acceptance and FIFO push/pop strobes from the registered fill level.
    always_comb begin
        ack_s  = in_bus.cyc & in_bus.stb & in_bus.we & (fifo_cnt_r != 2'd2) & ~RST_I;
        push_s = ack_s;
        pop_s  = (fifo_cnt_r != 2'd0) & out_bus.ack;
    end

    assign in_bus.ack  = ack_s;
    assign out_bus.stb = (fifo_cnt_r != 2'd0);
    assign out_bus.we  = (fifo_cnt_r != 2'd0);
    assign out_bus.dat = mem_r[rd_ptr_r];
    assign out_bus.cyc = cyc_s;
    assign SHORT_O     = short_s;

    // Two-entry FIFO storage, pointers and fill level; head entry drives DAT_O.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            mem_r[0]   <= 2'b00;
            mem_r[1]   <= 2'b00;
            rd_ptr_r   <= 1'b0;
            wr_ptr_r   <= 1'b0;
            fifo_cnt_r <= 2'd0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= sign_decide(in_bus.dat);
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + 2'd1;
                2'b01:   fifo_cnt_r <= fifo_cnt_r - 2'd1;
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // Frame state and output-transfer counter registers.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_r <= IDLE;
            count_r <= '0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
        end
    end

    // Frame next-state: count output transfers, wrap at NSYM, close short frames.
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        case (state_r)
            IDLE: begin
                count_s = '0;
                if (pop_s) begin
                    // A symbol left over from the previous frame's final cycle
                    // is already the first transfer of the new frame.
                    count_s = CW'(1);
                    state_s = ACTIVE;
                end else if (push_s || (fifo_cnt_r != 2'd0)) begin
                    state_s = ACTIVE;
                end else begin
                    state_s = IDLE;
                end
            end
            ACTIVE: begin
                if (pop_s) begin
                    if (count_r == CW'(NSYM - 1)) begin
                        state_s = IDLE;
                        count_s = '0;
                    end else begin
                        state_s = ACTIVE;
                        count_s = count_r + CW'(1);
                    end
                end else if (!in_bus.cyc && (fifo_cnt_r == 2'd0)) begin
                    state_s = CLOSE;
                end else begin
                    state_s = ACTIVE;
                end
            end
            CLOSE: begin
                state_s = IDLE;
                count_s = '0;
            end
            default: begin
                state_s = IDLE;
                count_s = '0;
            end
        endcase
    end

    // Frame outputs decoded from the registered state.
    always_comb begin
        cyc_s   = 1'b0;
        short_s = 1'b0;
        case (state_r)
            IDLE: begin
                cyc_s   = 1'b0;
                short_s = 1'b0;
            end
            ACTIVE: begin
                cyc_s   = 1'b1;
                short_s = 1'b0;
            end
            CLOSE: begin
                cyc_s   = 1'b0;
                short_s = 1'b1;
            end
            default: begin
                cyc_s   = 1'b0;
                short_s = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_qpsk_demap.sv
// Directed and randomised self-checking bench for qpsk_demap.
module tb_qpsk_demap;
    localparam int NSYM = 192;
    localparam int DW   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic short_o;
    logic ack_dir = 1'b0;
    logic ack_rand = 1'b0;
    logic rand_en = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [1:0] obs_q[$];
    logic [1:0] exp_q[$];
    int xfer_cnt = 0;
    int acc_cnt = 0;
    int short_cnt = 0;
    int xfer_no_cyc = 0;

    qpsk_demap_if #(.W(2*DW)) in_bus ();
    qpsk_demap_if #(.W(2))    out_bus ();

    qpsk_demap #(.NSYM(NSYM), .DW(DW)) dut (
        .CLK_I   (clk),
        .RST_I   (rst),
        .in_bus  (in_bus),
        .out_bus (out_bus),
        .SHORT_O (short_o)
    );

    always #5 clk = ~clk;

    assign out_bus.ack = rand_en ? ack_rand : ack_dir;

    // Random downstream acknowledge, changed just after each rising edge.
    always begin
        @(posedge clk);
        #1;
        ack_rand = ($urandom_range(0, 2) != 0);
    end

    // Monitor: log accepted inputs (sign model) and output transfers.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_bus.ack) begin
                exp_q.push_back({in_bus.dat[2*DW-1], in_bus.dat[DW-1]});
                acc_cnt++;
            end
            if (out_bus.stb && out_bus.ack) begin
                obs_q.push_back(out_bus.dat);
                xfer_cnt++;
                if (!out_bus.cyc) xfer_no_cyc++;
            end
            if (short_o) short_cnt++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        obs_q.delete();
        exp_q.delete();
        xfer_cnt = 0;
        acc_cnt = 0;
        short_cnt = 0;
        xfer_no_cyc = 0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Present one sample and hold it until accepted; returns at edge+1.
    task automatic send(input logic [2*DW-1:0] d);
        bit got;
        got = 1'b0;
        in_bus.dat = d;
        in_bus.stb = 1'b1;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            if (in_bus.ack) got = 1'b1;
        end
        if (!got) check_val("send_timeout", 32'd0, 32'd1);
        cycle();
    endtask

    task automatic wait_xfers(input int target);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 4000 && !done; i++) begin
            @(posedge clk);
            if (xfer_cnt >= target) done = 1'b1;
        end
        #1;
        if (!done) check_val("xfer_timeout", xfer_cnt, target);
    endtask

    task automatic compare_log(input string tag);
        int bad;
        int n;
        bad = 0;
        check_val({tag, "_len"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n && bad < 4; i++) begin
            if (obs_q[i] !== exp_q[i]) bad++;
            check_val({tag, "_sym"}, obs_q[i], exp_q[i]);
        end
    endtask

    logic [2*DW-1:0] map_in  [4];
    logic [1:0]      map_exp [4];
    logic [2*DW-1:0] bp_in   [5];
    logic [1:0]      bp_exp  [5];

    initial begin
        map_in[0] = {16'hFC18, 16'h03E8}; map_exp[0] = 2'b10; // Re=+1000, Im=-1000
        map_in[1] = {16'h0000, 16'h0000}; map_exp[1] = 2'b00; // zero
        map_in[2] = {16'hFFFF, 16'hFFFF}; map_exp[2] = 2'b11; // Re=-1, Im=-1
        map_in[3] = {16'h7FFF, 16'h8000}; map_exp[3] = 2'b01; // Re=min, Im=max
        bp_in[0] = {16'h0005, 16'hFFF0}; bp_exp[0] = 2'b01;
        bp_in[1] = {16'h8000, 16'h0001}; bp_exp[1] = 2'b10;
        bp_in[2] = {16'hFFFF, 16'h8000}; bp_exp[2] = 2'b11;
        bp_in[3] = {16'h0000, 16'h0000}; bp_exp[3] = 2'b00;
        bp_in[4] = {16'h7FFF, 16'hFFFF}; bp_exp[4] = 2'b01;

        in_bus.dat = '0;
        in_bus.we  = 1'b1;
        in_bus.stb = 1'b0;
        in_bus.cyc = 1'b0;

        // ---- Power-up reset ----
        cycle();
        @(negedge clk);
        check_val("rst_stb", out_bus.stb, 1'b0);
        check_val("rst_we", out_bus.we, 1'b0);
        check_val("rst_cyc", out_bus.cyc, 1'b0);
        check_val("rst_short", short_o, 1'b0);
        check_val("rst_dat", out_bus.dat, 2'b00);
        check_val("rst_ack", in_bus.ack, 1'b0);
        cycle();
        rst = 1'b0;
        cycle();

        // ---- Mid-stream reset with full FIFO ----
        in_bus.cyc = 1'b1;
        in_bus.stb = 1'b1;
        in_bus.dat = {16'hFFFF, 16'hFFFF};
        for (int i = 0; i < 4; i++) cycle();
        @(negedge clk);
        check_val("pre_rst_full_ack", in_bus.ack, 1'b0);
        check_val("pre_rst_cyc", out_bus.cyc, 1'b1);
        cycle();
        rst = 1'b1;
        cycle();
        @(negedge clk);
        check_val("mid_rst_ack", in_bus.ack, 1'b0);
        check_val("mid_rst_stb", out_bus.stb, 1'b0);
        check_val("mid_rst_cyc", out_bus.cyc, 1'b0);
        check_val("mid_rst_dat", out_bus.dat, 2'b00);
        check_val("mid_rst_short", short_o, 1'b0);
        cycle();
        rst = 1'b0;
        in_bus.stb = 1'b0;
        in_bus.cyc = 1'b0;
        clear_log();
        for (int i = 0; i < 4; i++) cycle();
        check_val("post_rst_short", short_cnt, 0);
        check_val("post_rst_stb", out_bus.stb, 1'b0);

        // ---- Sign mapping, one sample at a time ----
        clear_log();
        in_bus.cyc = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send(map_in[k]);
            in_bus.stb = 1'b0;
            @(negedge clk);
            check_val("map_dat", out_bus.dat, map_exp[k]);
            check_val("map_stb", out_bus.stb, 1'b1);
            cycle();
            ack_dir = 1'b1;
            cycle();
            ack_dir = 1'b0;
        end
        in_bus.cyc = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        check_val("map_xfers", xfer_cnt, 4);
        check_val("map_short", short_cnt, 1);
        check_val("map_cyc_end", out_bus.cyc, 1'b0);

        // ---- Full frame, back-to-back, ACK_I=1 ----
        clear_log();
        ack_dir = 1'b1;
        in_bus.cyc = 1'b1;
        for (int i = 0; i < NSYM; i++) begin
            send({16'(i * 523 - 40000), 16'(20000 - i * 311)});
        end
        in_bus.stb = 1'b0;
        wait_xfers(NSYM);
        @(negedge clk);
        check_val("full_cyc_drop", out_bus.cyc, 1'b0);
        check_val("full_xfers", xfer_cnt, NSYM);
        check_val("full_cyc_high", xfer_no_cyc, 0);
        compare_log("full");
        cycle();
        in_bus.cyc = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        check_val("full_no_short", short_cnt, 0);

        // ---- Backpressure ----
        clear_log();
        ack_dir = 1'b0;
        in_bus.cyc = 1'b1;
        in_bus.stb = 1'b1;
        in_bus.dat = bp_in[0];
        @(negedge clk);
        check_val("bp_acc0", in_bus.ack, 1'b1);
        cycle();
        in_bus.dat = bp_in[1];
        @(negedge clk);
        check_val("bp_acc1", in_bus.ack, 1'b1);
        cycle();
        in_bus.dat = bp_in[2];
        @(negedge clk);
        check_val("bp_full_ack", in_bus.ack, 1'b0);
        check_val("bp_head", out_bus.dat, bp_exp[0]);
        cycle();
        @(negedge clk);
        check_val("bp_hold_ack", in_bus.ack, 1'b0);
        check_val("bp_hold_dat", out_bus.dat, bp_exp[0]);
        check_val("bp_hold_stb", out_bus.stb, 1'b1);
        cycle();
        cycle();
        cycle();
        ack_dir = 1'b1;
        for (int k = 2; k < 5; k++) send(bp_in[k]);
        in_bus.stb = 1'b0;
        wait_xfers(5);
        check_val("bp_xfers", xfer_cnt, 5);
        for (int k = 0; k < 5; k++) begin
            if (k < obs_q.size()) check_val("bp_order", obs_q[k], bp_exp[k]);
        end
        in_bus.cyc = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        check_val("bp_short", short_cnt, 1);

        // ---- Short frame of 100 ----
        clear_log();
        in_bus.cyc = 1'b1;
        for (int i = 0; i < 100; i++) send($urandom());
        in_bus.stb = 1'b0;
        wait_xfers(100);
        in_bus.cyc = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        check_val("short_xfers", xfer_cnt, 100);
        check_val("short_pulse", short_cnt, 1);
        check_val("short_cyc", out_bus.cyc, 1'b0);
        compare_log("short");

        // ---- Random ACK_I/STB_I over 10 frames ----
        begin
            int total;
            int exp_short;
            int len;
            clear_log();
            total = 0;
            exp_short = 0;
            rand_en = 1'b1;
            in_bus.cyc = 1'b1;
            for (int f = 0; f < 10; f++) begin
                len = (f % 3 == 0) ? NSYM : 20 + $urandom_range(0, 80);
                for (int i = 0; i < len; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_bus.stb = 1'b0;
                        cycle();
                    end
                    send($urandom());
                end
                in_bus.stb = 1'b0;
                total += len;
                if (len < NSYM) begin
                    wait_xfers(total);
                    in_bus.cyc = 1'b0;
                    for (int i = 0; i < 4; i++) cycle();
                    in_bus.cyc = 1'b1;
                    exp_short++;
                end
            end
            wait_xfers(total);
            rand_en = 1'b0;
            ack_dir = 1'b0;
            in_bus.cyc = 1'b0;
            for (int i = 0; i < 4; i++) cycle();
            check_val("rand_acc", acc_cnt, total);
            check_val("rand_xfers", xfer_cnt, total);
            check_val("rand_shorts", short_cnt, exp_short);
            check_val("rand_cyc_end", out_bus.cyc, 1'b0);
            compare_log("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
